// File: rtl/micro_sequencer_pkg.sv
// Shared microcode definitions: sequencer states, microcode words, opcodes and wait decoding.
// Used by micro_rom, micro_sequencer and the microcode decoder.
package micro_sequencer_pkg;

   typedef enum logic [2:0] {
      FETCH0,
      FETCH1,
      FETCH2,
      EXEC,
      HALTED
   } seq_state_e;

   typedef enum logic [3:0] {
      PC_to_MAR,
      RAM_to_IR,
      INC_PC,
      ENDMICRO,
      RAM_to_A,
      START_MT,
      WAIT_MT,
      WAIT_UT,
      WAIT_FT,
      WAIT_DD,
      WAIT_GPU,
      WAIT_CYCLE,
      RAM_to_PC_ZF,
      RAM_to_PC_CF,
      HLT_CLK
   } microcode_e;

   localparam logic [7:0] OP_NOP      = 8'h00;
   localparam logic [7:0] OP_LDA_IMM  = 8'h01;
   localparam logic [7:0] OP_WAITMT   = 8'h20;
   localparam logic [7:0] OP_WAITALL  = 8'h21;
   localparam logic [7:0] OP_OVR_TEST = 8'h30;
   localparam logic [7:0] OP_HLT      = 8'hFF;

   localparam int MAX_STEPS_DEFAULT = 16;

   // busy is packed {gpu, dubdab, ftu, us, ms}
   function automatic logic wait_held(microcode_e mc, logic [4:0] busy);
      case (mc)
         WAIT_MT:  return busy[0];
         WAIT_UT:  return busy[1];
         WAIT_FT:  return busy[2];
         WAIT_DD:  return busy[3];
         WAIT_GPU: return busy[4];
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/micro_rom.sv
// Combinational microcode ROM: (opcode, step) -> microcode word plus a valid flag.
// Unknown opcodes return ENDMICRO with valid low.
module micro_rom
   import micro_sequencer_pkg::*;
(
   input  logic [7:0]  opcode,
   input  logic [3:0]  step,
   output microcode_e  word,
   output logic        valid
);

   always_comb begin
      word  = ENDMICRO;
      valid = 1'b1;
      case (opcode)
         OP_NOP: word = ENDMICRO;
         OP_LDA_IMM: begin
            case (step)
               4'd0:    word = PC_to_MAR;
               4'd1:    word = RAM_to_A;
               4'd2:    word = INC_PC;
               default: word = ENDMICRO;
            endcase
         end
         OP_WAITMT: begin
            case (step)
               4'd0:    word = START_MT;
               4'd1:    word = WAIT_MT;
               default: word = ENDMICRO;
            endcase
         end
         OP_WAITALL: begin
            case (step)
               4'd0:    word = WAIT_UT;
               4'd1:    word = WAIT_FT;
               4'd2:    word = WAIT_DD;
               4'd3:    word = WAIT_GPU;
               4'd4:    word = WAIT_CYCLE;
               4'd5:    word = RAM_to_PC_ZF;
               default: word = ENDMICRO;
            endcase
         end
         // Deliberately never terminates: exercises the step-limit overrun path.
         OP_OVR_TEST: word = step[0] ? RAM_to_PC_CF : INC_PC;
         OP_HLT:      word = HLT_CLK;
         default: begin
            word  = ENDMICRO;
            valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: three fetch states, ROM-driven execute with peripheral waits, halt.
// Optional single-step control is enabled by defining MICROSEQ_SINGLE_STEP_EN.
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter int MAX_STEPS = MAX_STEPS_DEFAULT
)(
   input  logic        clk,
   input  logic        nrst,
   input  logic [7:0]  ir_opcode,
   input  logic        busy_ms,
   input  logic        busy_us,
   input  logic        busy_ftu,
   input  logic        busy_dubdab,
   input  logic        busy_gpu,
`ifdef MICROSEQ_SINGLE_STEP_EN
   input  logic        ss_enable,
   input  logic        ss_step,
`endif
   output microcode_e  current_microcode,
   output logic [3:0]  step,
   output logic        fetching,
   output logic        halted,
   output logic        illegal_op,
   output logic        ucode_overrun
);

   localparam logic [3:0] LAST_STEP = 4'(MAX_STEPS - 1);

   seq_state_e  state;
   logic [7:0]  opcode_q;
   microcode_e  rom_word;
   logic        rom_valid;
   logic [4:0]  busy;
   logic        wait_hold;
   logic        advance;

   assign busy      = {busy_gpu, busy_dubdab, busy_ftu, busy_us, busy_ms};
   assign wait_hold = wait_held(rom_word, busy);

`ifdef MICROSEQ_SINGLE_STEP_EN
   assign advance = !ss_enable || ss_step;
`else
   assign advance = 1'b1;
`endif

   micro_rom u_rom (
      .opcode (opcode_q),
      .step   (step),
      .word   (rom_word),
      .valid  (rom_valid)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state         <= FETCH0;
         step          <= 4'd0;
         opcode_q      <= 8'h00;
         ucode_overrun <= 1'b0;
      end else begin
         ucode_overrun <= 1'b0;
         if (advance) begin
            case (state)
               FETCH0: state <= FETCH1;
               FETCH1: state <= FETCH2;
               FETCH2: begin
                  opcode_q <= ir_opcode;
                  step     <= 4'd0;
                  state    <= EXEC;
               end
               EXEC: begin
                  case (rom_word)
                     ENDMICRO: begin
                        state <= FETCH0;
                        step  <= 4'd0;
                     end
                     HLT_CLK: state <= HALTED;
                     default: begin
                        // A held wait never counts toward the step limit.
                        if (!wait_hold) begin
                           if (step == LAST_STEP) begin
                              state         <= FETCH0;
                              step          <= 4'd0;
                              ucode_overrun <= 1'b1;
                           end else begin
                              step <= step + 4'd1;
                           end
                        end
                     end
                  endcase
               end
               HALTED:  state <= HALTED;
               default: state <= FETCH0;
            endcase
         end
      end
   end

   always_comb begin
      case (state)
         FETCH0:  current_microcode = PC_to_MAR;
         FETCH1:  current_microcode = RAM_to_IR;
         FETCH2:  current_microcode = INC_PC;
         EXEC:    current_microcode = rom_word;
         HALTED:  current_microcode = HLT_CLK;
         default: current_microcode = PC_to_MAR;
      endcase
      if (!advance) current_microcode = WAIT_CYCLE;
   end

   assign fetching   = (state == FETCH0) || (state == FETCH1) || (state == FETCH2);
   assign halted     = (state == HALTED);
   assign illegal_op = (state == EXEC) && !rom_valid && advance;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: a program-table model expands each instruction
// into expected per-cycle outputs and random busy stimulus, replayed against the DUT.
module tb_micro_sequencer;
   import micro_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [7:0]  ir_opcode = 8'h00;
   logic        busy_ms = 1'b0, busy_us = 1'b0, busy_ftu = 1'b0;
   logic        busy_dubdab = 1'b0, busy_gpu = 1'b0;
   microcode_e  current_microcode;
   logic [3:0]  step;
   logic        fetching, halted, illegal_op, ucode_overrun;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   micro_sequencer dut (
      .clk               (clk),
      .nrst              (nrst),
      .ir_opcode         (ir_opcode),
      .busy_ms           (busy_ms),
      .busy_us           (busy_us),
      .busy_ftu          (busy_ftu),
      .busy_dubdab       (busy_dubdab),
      .busy_gpu          (busy_gpu),
      .current_microcode (current_microcode),
      .step              (step),
      .fetching          (fetching),
      .halted            (halted),
      .illegal_op        (illegal_op),
      .ucode_overrun     (ucode_overrun)
   );

   typedef struct packed {
      microcode_e  mc;
      logic [3:0]  step;
      logic        fetching;
      logic        halted;
      logic        illegal;
      logic        overrun;
   } vis_t;

   typedef struct {
      vis_t        v;
      logic        chk_step;
      logic [7:0]  op;
      logic [4:0]  busy;
   } ent_t;

   ent_t        exp_q[$];
   microcode_e  prog_q[$];
   logic        pend_ovr = 1'b0;
   localparam vis_t RESET_VIS = '{mc: PC_to_MAR, step: 4'd0, fetching: 1'b1,
                                  halted: 1'b0, illegal: 1'b0, overrun: 1'b0};

   function automatic string fmt(vis_t v);
      return $sformatf("%s step=%0d fetch=%0b halt=%0b ill=%0b ovr=%0b",
                       v.mc.name(), v.step, v.fetching, v.halted, v.illegal, v.overrun);
   endfunction

   function automatic vis_t sample();
      vis_t v;
      v.mc = current_microcode; v.step = step; v.fetching = fetching;
      v.halted = halted; v.illegal = illegal_op; v.overrun = ucode_overrun;
      return v;
   endfunction

   // Instruction programs as the instruction set defines them; returns 0 for undefined opcodes.
   task automatic load_program(input logic [7:0] op, output logic legal);
      prog_q.delete();
      legal = 1'b1;
      case (op)
         8'h00: prog_q.push_back(ENDMICRO);
         8'h01: begin
            prog_q.push_back(PC_to_MAR); prog_q.push_back(RAM_to_A);
            prog_q.push_back(INC_PC);    prog_q.push_back(ENDMICRO);
         end
         8'h20: begin
            prog_q.push_back(START_MT); prog_q.push_back(WAIT_MT); prog_q.push_back(ENDMICRO);
         end
         8'h21: begin
            prog_q.push_back(WAIT_UT);  prog_q.push_back(WAIT_FT);   prog_q.push_back(WAIT_DD);
            prog_q.push_back(WAIT_GPU); prog_q.push_back(WAIT_CYCLE);
            prog_q.push_back(RAM_to_PC_ZF); prog_q.push_back(ENDMICRO);
         end
         8'h30: for (int i = 0; i < 20; i++) prog_q.push_back((i % 2) ? RAM_to_PC_CF : INC_PC);
         8'hFF: prog_q.push_back(HLT_CLK);
         default: begin
            prog_q.push_back(ENDMICRO);
            legal = 1'b0;
         end
      endcase
   endtask

   function automatic int busy_index(microcode_e mc);
      case (mc)
         WAIT_MT:  return 0;
         WAIT_UT:  return 1;
         WAIT_FT:  return 2;
         WAIT_DD:  return 3;
         WAIT_GPU: return 4;
         default:  return -1;
      endcase
   endfunction

   function automatic logic is_defined(logic [7:0] op);
      return op inside {8'h00, 8'h01, 8'h20, 8'h21, 8'h30, 8'hFF};
   endfunction

   task automatic push_exp(input microcode_e mc, input int st, input logic chk, input logic f,
                           input logic h, input logic il, input logic ov,
                           input logic [7:0] op, input logic [4:0] b);
      ent_t e;
      e.v.mc = mc; e.v.step = chk ? 4'(st) : 4'd0; e.v.fetching = f; e.v.halted = h;
      e.v.illegal = il; e.v.overrun = ov; e.chk_step = chk; e.op = op; e.busy = b;
      exp_q.push_back(e);
   endtask

   // Expands one instruction into expected cycles; hold < 0 picks a random busy length per wait.
   task automatic add_instr(input logic [7:0] op, input int hold, input int halt_cycles);
      logic       legal;
      logic [4:0] b;
      int         w, k;
      logic       ended;
      load_program(op, legal);
      push_exp(PC_to_MAR, 0, 1'b1, 1'b1, 1'b0, 1'b0, pend_ovr, op, 5'($urandom_range(0, 31)));
      pend_ovr = 1'b0;
      push_exp(RAM_to_IR, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, op, 5'($urandom_range(0, 31)));
      push_exp(INC_PC,    0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, op, 5'($urandom_range(0, 31)));
      ended = 1'b0;
      for (int i = 0; i < 16 && !ended; i++) begin
         w = busy_index(prog_q[i]);
         if (w >= 0) begin
            k = (hold >= 0) ? hold : int'($urandom_range(0, 4));
            for (int j = 0; j < k; j++) begin
               b = 5'($urandom_range(0, 31)); b[w] = 1'b1;
               push_exp(prog_q[i], i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op, b);
            end
            b = 5'($urandom_range(0, 31)); b[w] = 1'b0;
            push_exp(prog_q[i], i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op, b);
         end else begin
            push_exp(prog_q[i], i, 1'b1, 1'b0, 1'b0, !legal, 1'b0, op, 5'($urandom_range(0, 31)));
         end
         if (prog_q[i] == HLT_CLK) begin
            for (int j = 0; j < halt_cycles; j++)
               push_exp(HLT_CLK, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, op, 5'($urandom_range(0, 31)));
            ended = 1'b1;
         end
         if (prog_q[i] == ENDMICRO) ended = 1'b1;
      end
      if (!ended) pend_ovr = 1'b1;
   endtask

   task automatic drive_cycle(input ent_t e, output vis_t obs);
      obs = sample();
      if (!e.chk_step) obs.step = 4'd0;
      ir_opcode = e.op;
      {busy_gpu, busy_dubdab, busy_ftu, busy_us, busy_ms} = e.busy;
      @(posedge clk); #1;
   endtask

   task automatic release_reset();
      {busy_gpu, busy_dubdab, busy_ftu, busy_us, busy_ms} = 5'b0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      pend_ovr = 1'b0;
   endtask

   task automatic test_reset();
      vis_t obs;
      repeat (2) @(posedge clk);
      #1;
      obs = sample();
      n_checks++;
      if (obs !== RESET_VIS) begin
         n_fail++; $display("FAIL reset_state: got %s, expected %s", fmt(obs), fmt(RESET_VIS));
      end
      release_reset();
   endtask

   task automatic test_fetch_nop();
      ent_t e; vis_t obs;
      repeat (3) add_instr(8'h00, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL nop_seq: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
   endtask

   task automatic test_lda();
      ent_t e; vis_t obs;
      add_instr(8'h01, -1, 0);
      add_instr(8'h00, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL lda_seq: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
   endtask

   task automatic test_waits();
      ent_t e; vis_t obs;
      add_instr(8'h20, 5, 0);
      add_instr(8'h20, 0, 0);
      add_instr(8'h21, -1, 0);
      add_instr(8'h21, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL wait_seq: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
   endtask

   task automatic test_illegal();
      ent_t e; vis_t obs;
      logic [7:0] op;
      add_instr(8'h7E, -1, 0);
      add_instr(8'h00, -1, 0);
      do op = 8'($urandom_range(0, 255)); while (is_defined(op));
      add_instr(op, -1, 0);
      add_instr(8'h01, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL illegal_seq: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
   endtask

   task automatic test_overrun();
      ent_t e; vis_t obs;
      add_instr(8'h30, -1, 0);
      add_instr(8'h00, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL overrun_seq: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
   endtask

   task automatic test_random();
      ent_t e; vis_t obs;
      logic [7:0] ops [7] = '{8'h00, 8'h01, 8'h20, 8'h21, 8'h30, 8'h7E, 8'h42};
      for (int n = 0; n < 30; n++) add_instr(ops[$urandom_range(0, 6)], -1, 0);
      add_instr(8'h00, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL random_seq: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
   endtask

   task automatic test_halt();
      ent_t e; vis_t obs;
      add_instr(8'h00, -1, 0);
      add_instr(8'hFF, -1, 12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL halt_seq: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
      #2 nrst = 1'b0;
      #1 obs = sample();
      n_checks++;
      if (obs !== RESET_VIS) begin
         n_fail++; $display("FAIL halt_reset: got %s, expected %s", fmt(obs), fmt(RESET_VIS));
      end
      release_reset();
      add_instr(8'h01, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL after_halt: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      ent_t e; vis_t obs;
      add_instr(8'h20, 50, 0);
      // fetch (3) + START_MT + three held WAIT_MT cycles; the DUT is still waiting afterwards
      for (int i = 0; i < 7; i++) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL pre_wait_reset: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
      exp_q.delete();
      #2 nrst = 1'b0;
      #1 obs = sample();
      n_checks++;
      if (obs !== RESET_VIS) begin
         n_fail++; $display("FAIL wait_reset: got %s, expected %s", fmt(obs), fmt(RESET_VIS));
      end
      release_reset();
      add_instr(8'h00, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL after_wait_reset: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
   endtask

   task automatic test_reset_kills_pulse();
      ent_t e; vis_t obs;
      add_instr(8'h30, -1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); drive_cycle(e, obs); n_checks++;
         if (obs !== e.v) begin
            n_fail++; $display("FAIL pulse_pre: got %s, expected %s", fmt(obs), fmt(e.v));
         end
      end
      n_checks++;
      if (ucode_overrun !== 1'b1) begin
         n_fail++; $display("FAIL pulse_live: ucode_overrun got %b, expected 1", ucode_overrun);
      end
      #2 nrst = 1'b0;
      #1 obs = sample();
      n_checks++;
      if (obs !== RESET_VIS) begin
         n_fail++; $display("FAIL pulse_reset: got %s, expected %s", fmt(obs), fmt(RESET_VIS));
      end
      release_reset();
   endtask

   initial begin
      test_reset();
      test_fetch_nop();
      test_lda();
      test_waits();
      test_illegal();
      test_overrun();
      test_random();
      test_reset_mid_wait();
      test_reset_kills_pulse();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
